// File: rtl/stump_mem_arbiter.sv
// Stump memory arbiter: shares one single-port memory between the CPU and an
// external requester, sequencing each access through a fixed wait-state count.
module stump_mem_arbiter #(
   parameter int unsigned WAIT_STATES   = 1,
   parameter int unsigned EXT_MAX_WAIT  = 4,
   parameter int unsigned EXT_MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   output logic [15:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        ext_req,
   input  logic        ext_wen,
   input  logic [15:0] ext_addr,
   input  logic [15:0] ext_wdata,
   output logic        ext_ack,
   output logic [15:0] ext_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_ren,
   output logic        mem_wen,
   input  logic [15:0] mem_rdata
);

   localparam int unsigned SLOT_W  = (EXT_MAX_WAIT  > 0) ? $clog2(EXT_MAX_WAIT + 1)  : 1;
   localparam int unsigned BURST_W = (EXT_MAX_BURST > 0) ? $clog2(EXT_MAX_BURST + 1) : 1;
   localparam logic [3:0]         WAIT_INIT = 4'(WAIT_STATES);
   localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(EXT_MAX_WAIT);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(EXT_MAX_BURST);

   typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_e;

   state_e             state_q, state_d;
   logic [3:0]         wait_q, wait_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [15:0]        mem_addr_q, mem_addr_d;
   logic [15:0]        mem_wdata_q, mem_wdata_d;
   logic               mem_ren_q, mem_ren_d;
   logic               mem_wen_q, mem_wen_d;
   logic [15:0]        cpu_rdata_q, cpu_rdata_d;
   logic [15:0]        ext_rdata_q, ext_rdata_d;
   logic               ext_ack_q, ext_ack_d;

   logic cpu_req;
   logic cpu_final;
   logic ext_win;

   assign cpu_req   = cpu_ren | cpu_wen;
   assign cpu_final = (state_q == CPU_ACC) && (wait_q == '0);

   // External side takes the bus when the CPU is quiet, when the CPU has used up
   // its slots, or to continue a burst that has not yet hit its limit.
   assign ext_win = ext_req &&
                    (!cpu_req || (slot_q == SLOT_MAX) ||
                     ((state_q == EXT_ACC) && (burst_q < BURST_MAX)));

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d     = state_q;
      wait_d      = wait_q;
      slot_d      = slot_q;
      burst_d     = burst_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_ren_d   = mem_ren_q;
      mem_wen_d   = mem_wen_q;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      ext_ack_d   = 1'b0;

      if ((state_q != IDLE) && (wait_q != '0)) begin
         wait_d = wait_q - 4'd1;
      end else begin
         if ((state_q == CPU_ACC) && !mem_wen_q) begin
            cpu_rdata_d = mem_rdata;
         end
         if (state_q == EXT_ACC) begin
            ext_ack_d = 1'b1;
            if (!mem_wen_q) begin
               ext_rdata_d = mem_rdata;
            end
         end

         if (ext_win) begin
            state_d     = EXT_ACC;
            wait_d      = WAIT_INIT;
            slot_d      = '0;
            if (burst_q < BURST_MAX) begin
               burst_d = burst_q + BURST_W'(1);
            end
            mem_addr_d  = ext_addr;
            mem_wdata_d = ext_wdata;
            mem_wen_d   = ext_wen;
            mem_ren_d   = !ext_wen;
         end else if (cpu_req) begin
            state_d     = CPU_ACC;
            wait_d      = WAIT_INIT;
            burst_d     = '0;
            if (ext_req) begin
               slot_d = slot_q + SLOT_W'(1);
            end
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_wen_d   = cpu_wen;
            mem_ren_d   = !cpu_wen;
         end else begin
            state_d   = IDLE;
            wait_d    = '0;
            burst_d   = '0;
            mem_ren_d = 1'b0;
            mem_wen_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         slot_q      <= '0;
         burst_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
         ext_ack_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         wait_q      <= wait_d;
         slot_q      <= slot_d;
         burst_q     <= burst_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_ren_q   <= mem_ren_d;
         mem_wen_q   <= mem_wen_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
         ext_ack_q   <= ext_ack_d;
      end
   end

   // The CPU is released only in the last cycle of its own access, and is held
   // for the whole of reset.
   assign cpu_stall = !rst || (cpu_req && !cpu_final);

   assign cpu_rdata = cpu_rdata_q;
   assign ext_ack   = ext_ack_q;
   assign ext_rdata = ext_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_ren   = mem_ren_q;
   assign mem_wen   = mem_wen_q;

endmodule
